// File: rtl/per2bpm.sv
// Converts a measured button period (in time pulses) into a tempo in BPM using a
// serial restoring divider. Optional macro PER2BPM_AVERAGE_EN averages the last 4 periods.
module per2bpm #(
    parameter int PULSE_PER_NS = 5120,
    parameter int BPM_PER_SIZE = 17,
    parameter int BPM_MAX      = 250,
    parameter int BPM_SIZE     = 9
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [BPM_PER_SIZE-1:0] btn_per_i,
    input  logic                    btn_per_valid_i,
    output logic [BPM_SIZE-1:0]     bpm_o,
    output logic                    bpm_valid_o,
    output logic                    busy_o
);

    // state | meaning
    // IDLE  | waiting for a period strobe
    // DIV   | one quotient bit per clock, MSB first
    // DONE  | clamp and publish the result
    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    localparam logic [63:0] DIVIDEND_64 = 64'd60_000_000_000 / 64'(PULSE_PER_NS);
    localparam int DIV_W = $clog2(DIVIDEND_64 + 64'd1);
    localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(DIVIDEND_64);
    localparam int CNT_W = $clog2(DIV_W);
    localparam int RW = BPM_PER_SIZE + 1;

    state_t state_q, state_d;

    logic [BPM_PER_SIZE-1:0] divisor_in;
    logic [BPM_PER_SIZE-1:0] divisor_q;
    logic [DIV_W-1:0]        quot_q;
    logic [RW-1:0]           rem_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [RW:0]             rem_sh;
    logic                    fits;
    logic                    start;
    logic                    last_iter;
    logic                    div_zero;

    assign start     = (state_q == IDLE) && btn_per_valid_i;
    assign rem_sh    = {rem_q, quot_q[DIV_W-1]};
    assign fits      = rem_sh >= {2'b00, divisor_q};
    assign last_iter = (cnt_q == CNT_W'(DIV_W - 1));
    assign div_zero  = (divisor_q == '0);

`ifdef PER2BPM_AVERAGE_EN
    // The incoming sample is the fourth history entry; only the three previous are stored.
    logic [BPM_PER_SIZE-1:0] hist_q [3];
    logic                    hist_full_q;
    logic [BPM_PER_SIZE+1:0] sum;

    always_comb begin
        sum = '0;
        if (hist_full_q)
            sum = {2'b00, btn_per_i} + {2'b00, hist_q[0]} + {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
        else
            sum = {btn_per_i, 2'b00};
        divisor_in = BPM_PER_SIZE'(sum >> 2);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 3; i++) hist_q[i] <= '0;
            hist_full_q <= 1'b0;
        end else if (start) begin
            if (hist_full_q) begin
                hist_q[2] <= hist_q[1];
                hist_q[1] <= hist_q[0];
                hist_q[0] <= btn_per_i;
            end else begin
                for (int i = 0; i < 3; i++) hist_q[i] <= btn_per_i;
            end
            hist_full_q <= 1'b1;
        end
    end
`else
    assign divisor_in = btn_per_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (btn_per_valid_i) state_d = DIV;
            DIV:     if (div_zero || last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            divisor_q   <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            bpm_o       <= '0;
            bpm_valid_o <= 1'b0;
        end else begin
            bpm_valid_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        divisor_q <= divisor_in;
                        quot_q    <= DIVIDEND;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                    end
                end
                DIV: begin
                    // A zero divisor saturates the quotient so the clamp yields BPM_MAX.
                    if (div_zero) begin
                        quot_q <= '1;
                    end else begin
                        rem_q  <= fits ? RW'(rem_sh - {2'b00, divisor_q}) : RW'(rem_sh);
                        quot_q <= {quot_q[DIV_W-2:0], fits};
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    bpm_o       <= (quot_q > DIV_W'(BPM_MAX)) ? BPM_SIZE'(BPM_MAX)
                                                               : quot_q[BPM_SIZE-1:0];
                    bpm_valid_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_per2bpm.sv
// Directed, table-driven bench for per2bpm: period-to-BPM results, latency, drop and reset cases.
module tb_per2bpm;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [16:0] btn_per_i = '0;
    logic        btn_per_valid_i = 1'b0;
    logic [8:0]  bpm_o;
    logic        bpm_valid_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    per2bpm dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .btn_per_i       (btn_per_i),
        .btn_per_valid_i (btn_per_valid_i),
        .bpm_o           (bpm_o),
        .bpm_valid_o     (bpm_valid_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [16:0] per;
        logic [8:0]  bpm;
        int          lat;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Strobe one period and wait for the result; lat counts edges after the sampling edge.
    task automatic run_vec(input logic [16:0] per, input logic [8:0] exp_bpm, input int exp_lat);
        int lat;
        bit seen;
        bit busy_ok;
        logic [8:0] held;
        btn_per_i       = per;
        btn_per_valid_i = 1'b1;
        step();
        btn_per_valid_i = 1'b0;
        lat     = 0;
        seen    = 1'b0;
        busy_ok = (busy_o == 1'b1) && (bpm_valid_o == 1'b0);
        while (!seen && lat < 60) begin
            step();
            lat++;
            if (bpm_valid_o) seen = 1'b1;
            else if (!busy_o) busy_ok = 1'b0;
        end
        check($sformatf("result_seen per=%0d", per), seen, 1);
        check($sformatf("latency per=%0d", per), lat, exp_lat);
        check($sformatf("bpm per=%0d", per), bpm_o, exp_bpm);
        check($sformatf("busy_during per=%0d", per), busy_ok, 1);
        held = bpm_o;
        step();
        check($sformatf("valid_one_cycle per=%0d", per), bpm_valid_o, 0);
        check($sformatf("bpm_hold per=%0d", per), bpm_o, held);
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (bpm_valid_o) pulses++;
        end
    endtask

    initial begin
        vec_t vecs[7];
        int   pulses;
        int   lat;
        bit   seen;

        vecs[0] = '{per: 17'd46875,  bpm: 9'd250, lat: 25};
        vecs[1] = '{per: 17'd93750,  bpm: 9'd125, lat: 25};
        vecs[2] = '{per: 17'd117188, bpm: 9'd99,  lat: 25};
        vecs[3] = '{per: 17'd131071, bpm: 9'd89,  lat: 25};
        vecs[4] = '{per: 17'd10000,  bpm: 9'd250, lat: 25};
        vecs[5] = '{per: 17'd0,      bpm: 9'd250, lat: 2};
        vecs[6] = '{per: 17'd58593,  bpm: 9'd200, lat: 25};

        repeat (3) @(posedge clk_i);
        #1;
        check("reset_bpm", bpm_o, 0);
        check("reset_valid", bpm_valid_o, 0);
        check("reset_busy", busy_o, 0);
        rst_i = 1'b0;
        step();
        check("idle_busy", busy_o, 0);

`ifdef PER2BPM_AVERAGE_EN
        run_vec(17'd46875, 9'd250, 25);
        run_vec(17'd46875, 9'd250, 25);
        run_vec(17'd46875, 9'd250, 25);
        run_vec(17'd93750, 9'd200, 25);
`else
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i].per, vecs[i].bpm, vecs[i].lat);
            step();
        end

        // Second strobe while busy must be dropped without queuing.
        btn_per_i       = 17'd46875;
        btn_per_valid_i = 1'b1;
        step();
        btn_per_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) step();
        btn_per_i       = 17'd93750;
        btn_per_valid_i = 1'b1;
        step();
        btn_per_valid_i = 1'b0;
        check("drop_busy", busy_o, 1);
        lat  = 5;
        seen = 1'b0;
        while (!seen && lat < 60) begin
            step();
            lat++;
            if (bpm_valid_o) seen = 1'b1;
        end
        check("drop_latency", lat, 25);
        check("drop_bpm", bpm_o, 250);
        count_pulses(40, pulses);
        check("drop_no_second_result", pulses, 0);
        check("drop_bpm_hold", bpm_o, 250);

        // Reset in the middle of a division discards the result.
        btn_per_i       = 17'd93750;
        btn_per_valid_i = 1'b1;
        step();
        btn_per_valid_i = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("mid_busy", busy_o, 1);
        rst_i = 1'b1;
        #1;
        check("midrst_bpm", bpm_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_valid", bpm_valid_o, 0);
        step();
        rst_i = 1'b0;
        count_pulses(40, pulses);
        check("midrst_no_result", pulses, 0);
        check("midrst_bpm_after", bpm_o, 0);
        run_vec(17'd93750, 9'd125, 25);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL timeout: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/per2bpm.md
PER2BPM -- requirements
Module: per2bpm

Interface
REQ-001 Parameter: PULSE_PER_NS, default 5120, time-pulse period in ns; fixes the divider dividend.
REQ-002 Parameter: BPM_PER_SIZE, default 17, width of the incoming period word, in time pulses.
REQ-003 Parameter: BPM_MAX, default 250, saturation ceiling of the BPM result.
REQ-004 Parameter: BPM_SIZE, default 9, width of the BPM output.
REQ-005 Port: clk_i  input  1  system clock; all logic on rising edge.
REQ-006 Port: rst_i  input  1  reset, asynchronous, active-high.
REQ-007 Port: btn_per_i  input  BPM_PER_SIZE  measured button period, in time pulses, from the period counter.
REQ-008 Port: btn_per_valid_i  input  1  one-cycle strobe; btn_per_i is valid in this cycle.
REQ-009 Port: bpm_o  output  BPM_SIZE  last computed tempo, beats per minute, registered.
REQ-010 Port: bpm_valid_o  output  1  one-cycle strobe; bpm_o just updated.
REQ-011 Port: busy_o  output  1  high while a division is in progress; period strobes are dropped.

Function
REQ-012 Elaboration constant DIVIDEND = 60_000_000_000 / PULSE_PER_NS, integer floor: 11_718_750 by default.
REQ-013 Constant DIV_W = bit width of DIVIDEND: 24 by default, and equal to the iteration count.
REQ-014 FSM states: IDLE, DIV, DONE; reset state IDLE.
REQ-015 IDLE with btn_per_valid_i=1 at edge N: latch the divisor (btn_per_i or the average, see REQ-026), load DIVIDEND, clear the remainder and iteration count, go to DIV.
REQ-016 DIV: restoring division, one quotient bit per clock, MSB first; remainder width BPM_PER_SIZE+1.
REQ-017 DIV runs edges N+1..N+DIV_W, then goes to DONE.
REQ-018 DONE, edge N+DIV_W+1: register bpm_o = min(quotient, BPM_MAX), pulse bpm_valid_o for exactly one cycle, return to IDLE.
REQ-019 Latency: bpm_valid_o is high in the cycle after edge N+25 by default.
REQ-020 Divisor 0: skip the division; next edge goes straight to DONE with bpm_o=BPM_MAX.
REQ-021 busy_o = 1 in DIV and DONE, 0 in IDLE.
REQ-022 btn_per_valid_i while busy_o=1: ignored, no queuing, state unchanged.
REQ-023 The quotient is kept at full DIV_W width until the clamp; no truncation before the compare.
REQ-024 bpm_o holds its value between updates.

Reset
REQ-025 rst_i asserted, including mid-division: the FSM goes to IDLE; bpm_o=0, bpm_valid_o=0, busy_o=0; the divider registers are cleared; the in-flight result is discarded and no strobe is issued.

Configuration
REQ-026 Macro PER2BPM_AVERAGE_EN defined: a 4-entry period history feeds the divisor.
  - Divisor = (new sample + 3 most recent stored) >> 2, using a BPM_PER_SIZE+2 bit sum.
  - The first accepted sample after reset fills all 4 entries.
  - Only accepted (non-dropped) samples enter the history.
  - Reset clears the history and its fill flag.
REQ-027 Macro undefined: divisor = btn_per_i directly; no history storage is synthesised.

Verification
REQ-028 Default params, btn_per_i=46875 strobe -> bpm_o=250, bpm_valid_o 25 cycles after the sampling edge, busy_o high throughout.
REQ-029 btn_per_i=93750 -> bpm_o=125; btn_per_i=117188 -> bpm_o=99 (floor); btn_per_i=131071 -> bpm_o=89.
REQ-030 btn_per_i=10000 -> bpm_o=250 (clamp); btn_per_i=0 -> bpm_o=250, bpm_valid_o at the second edge after sampling.
REQ-031 Second strobe (btn_per_i=93750) 5 cycles after a first strobe of 46875 -> second strobe ignored, single result bpm_o=250.
REQ-032 rst_i pulsed 10 cycles into a division -> no bpm_valid_o, bpm_o=0, busy_o=0; a new strobe of 93750 afterwards -> bpm_o=125.
REQ-033 With PER2BPM_AVERAGE_EN, strobes 46875,46875,46875,93750 -> bpm_o = 250, 250, 250, then 200 (divisor 58593).
